booth_seq_multiplier: RTL
=========================

Name: booth_seq_multiplier

Overview:
- Multi-cycle signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Sits directly upstream of the adder library: it performs one add/subtract per cycle through a WIDTH+1-bit add/sub stage.
- Its narrowed overflow flags use the same pos/neg convention as the carry-select adder outputs.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand width in bits (two's complement); must be >= 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands A, B valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  signed multiplicand.
- B  input  WIDTH  signed multiplier.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- P  output  2*WIDTH  signed product A*B.
- posOverflow  output  1  P > max signed WIDTH value (truncated product overflows positive).
- negOverflow  output  1  P < min signed WIDTH value.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; P=0; posOverflow=0; negOverflow=0; counter=0.
  - Reset takes priority over every other event, including mid-RUN and mid-DONE; any in-flight operation is discarded with no output.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k, latch:
    - acc = 0 (WIDTH+1 bits);
    - mcand = sign-extended A (WIDTH+1 bits);
    - q = B;
    - q_1 = 0;
    - cnt = 0.
  - Go to RUN.
- RUN (in_ready=0, out_valid=0): one Booth step per cycle.
  - {q[0],q_1}=01: acc += mcand.
  - {q[0],q_1}=10: acc -= mcand.
  - 00 or 11: no add.
  - Then arithmetic right shift of {acc,q,q_1} by 1; cnt += 1.
  - When cnt reaches WIDTH-1 at the start of a step, that step is the last one; go to DONE.
  - Steps therefore occur at edges k+1 .. k+WIDTH.
- Accumulator width: WIDTH+1 bits, so A = -2^(WIDTH-1) negation never overflows. No step may wrap.
- DONE:
  - Entered at edge k+WIDTH. out_valid=1 from then on.
  - P = {acc[WIDTH-1:0], q}, i.e. the low 2*WIDTH bits of the shifted register, excluding q_1.
  - posOverflow = (P[2W-1]==0) && (P[2W-1:WIDTH-1] != 0).
  - negOverflow = (P[2W-1]==1) && (P[2W-1:WIDTH-1] != all-ones).
  - P and both flags are registered and stable while out_valid=1.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. P and the flags keep their last values (do not clear).
- Latency: exactly WIDTH cycles from accept edge to out_valid high. Throughput is one operation per WIDTH+2 cycles minimum (accept, WIDTH steps, handoff, return to IDLE).
- Backpressure: out_ready=0 holds DONE indefinitely. in_valid is ignored outside IDLE. A and B may change freely after the accept edge.
- No same-cycle bypass: in DONE, in_ready=0 even when out_ready=1. The next accept happens at the earliest one cycle after handoff.
- Simultaneous in_valid and rst_n=0: reset wins and nothing is accepted.
- All outputs are driven from registers; there is no combinational path from inputs to outputs except none (in_ready is decoded from state only).

Decomposition:
- Shared package (mult_pkg):
  - state enum IDLE/RUN/DONE, 2-bit encoding;
  - Booth op encoding NOP/ADD/SUB;
  - function booth_op(q0, q_1);
  - localparam helpers for signed WIDTH max/min.
- Sub-module booth_addsub (WIDTH+1 bits, combinational): inputs acc, mcand, op; output next_acc. Subtraction is implemented as acc + ~mcand + 1 (Cin=1), matching the adder library's A/B/Cin usage. The carry-select adder can be dropped in here later.
- All sequencing, the counter, the shift register and the flag computation live in booth_seq_multiplier.

Test Plan:
- A=7, B=-3, out_ready=1 -> out_valid exactly 32 cycles after accept; P=-21 (0xFFFF_FFFF_FFFF_FFEB); posOverflow=0, negOverflow=0.
- A=0x8000_0000, B=0x8000_0000 -> P=0x4000_0000_0000_0000; posOverflow=1, negOverflow=0.
- A=0x8000_0000, B=0xFFFF_FFFF -> P=0x0000_0000_8000_0000; posOverflow=1. Then A=0x0001_0000, B=0xFFFF_0000 -> P=-2^32; negOverflow=1.
- A=12345, B=0, out_ready=0 for 10 cycles after out_valid -> P=0 and out_valid held stable with in_ready=0. Then out_ready=1 for one cycle -> in_ready=1 on the next cycle.
- Accept A=100, B=50; assert rst_n=0 for one edge at step 10 -> out_valid=0, in_ready=1, P=0 next cycle. A new op A=-10, B=-8 then yields P=80.
- Back-to-back: in_valid held high with 64 random signed pairs and out_ready=1 -> each P matches the reference product. Each accept is spaced WIDTH+2 cycles apart, and no operand is accepted while busy.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {q[0], q_1}.
    function automatic booth_op_e booth_op(input logic q0, input logic q_1);
        booth_op_e op;
        case ({q0, q_1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    localparam int unsigned MAX_SIGNED_W = 64;

    // Largest / smallest two's complement value representable in w bits (w <= 64).
    function automatic logic signed [MAX_SIGNED_W-1:0] signed_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [MAX_SIGNED_W-1:0] signed_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// One Booth step's add/subtract stage; subtraction uses acc + ~mcand + 1.
module booth_addsub
    import mult_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] mcand_i,
    input  booth_op_e    op_i,
    output logic [W-1:0] next_acc_o
);

    logic [W-1:0] b_op;
    logic         cin;

    always_comb begin
        b_op = '0;
        cin  = 1'b0;
        case (op_i)
            OP_ADD: begin
                b_op = mcand_i;
                cin  = 1'b0;
            end
            OP_SUB: begin
                b_op = ~mcand_i;
                cin  = 1'b1;
            end
            default: begin
                b_op = '0;
                cin  = 1'b0;
            end
        endcase
        next_acc_o = acc_i + b_op + W'(cin);
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one add/sub per cycle, valid/ready on operand and result sides.
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 posOverflow,
    output logic                 negOverflow
);

    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    booth_op_e        op_c;
    logic [AW-1:0]    sum_c;
    logic [AW-1:0]    acc_sh_c;
    logic [WIDTH-1:0] q_sh_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH:0]   prod_hi_c;

    assign op_c = booth_op(q_q[0], q1_q);

    booth_addsub #(
        .W (AW)
    ) u_addsub (
        .acc_i      (acc_q),
        .mcand_i    (mcand_q),
        .op_i       (op_c),
        .next_acc_o (sum_c)
    );

    // Arithmetic right shift of {sum, q, q_1}; the final product excludes q_1.
    assign acc_sh_c  = {sum_c[AW-1], sum_c[AW-1:1]};
    assign q_sh_c    = {sum_c[0], q_q[WIDTH-1:1]};
    assign prod_c    = {acc_sh_c[WIDTH-1:0], q_sh_c};
    assign prod_hi_c = prod_c[PW-1:WIDTH-1];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        pos_d   = pos_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d   = '0;
                    mcand_d = {A[WIDTH-1], A};
                    q_d     = B;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sh_c;
                q_d   = q_sh_c;
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    p_d     = prod_c;
                    pos_d   = !prod_c[PW-1] && (prod_hi_c != '0);
                    neg_d   = prod_c[PW-1] && (prod_hi_c != '1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            cnt_q       <= '0;
            p_q         <= '0;
            pos_q       <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            q_q         <= q_d;
            q1_q        <= q1_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign P           = p_q;
    assign posOverflow = pos_q;
    assign negOverflow = neg_q;

endmodule
